// File: rtl/delta_dram_write_coalescer.sv
// delta_dram_write_coalescer
// Gathers single-word writes from the output extractor into contiguous runs
// and replays each run to the DRAM controller as one burst (req/ack header
// followed by wvalid/wready beats). A run closes when it is full, when a
// non-contiguous write arrives, after an idle timeout, or on a flush.
module delta_dram_write_coalescer #(
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 16,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        up_write,
    input  logic [ADDR_W-1:0]           up_addr,
    input  logic [DATA_W-1:0]           up_data,
    output logic                        up_write_done,
    input  logic                        up_flush,
    output logic                        flush_done,
    output logic                        dram_burst_req,
    output logic [ADDR_W-1:0]           dram_burst_addr,
    output logic [$clog2(BURST_LEN):0]  dram_burst_len,
    input  logic                        dram_burst_ack,
    output logic                        dram_wvalid,
    output logic [DATA_W-1:0]           dram_wdata,
    output logic                        dram_wlast,
    input  logic                        dram_wready,
    output logic                        err_misaligned
);
    localparam int PW = $clog2(BURST_LEN);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_COLLECT, S_REQ, S_DATA, S_FLUSH_ACK} state_t;

    state_t              state_q;
    logic [CW-1:0]       count_q;
    logic [PW-1:0]       ptr_q;
    logic [IW-1:0]       idle_q;
    logic [ADDR_W-1:0]   run_base_q;
    logic                flush_pend_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   buf_q [BURST_LEN];

    logic [ADDR_W-1:0]   next_addr;
    logic                pend, empty, full, accept, flush_any;
    logic                stall_jump, timeout_hit, fill_last, close_run, beat_last;

    // Word acceptance and run-closing decisions, all from current state.
    // pend excludes the done cycle so a still-held, already-accepted word is
    // neither accepted twice nor mistaken for a non-contiguous stall.
    assign next_addr   = run_base_q + ADDR_W'({count_q, 2'b00});
    assign pend        = up_write && !done_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(BURST_LEN));
    assign accept      = (state_q == S_COLLECT) && pend && !full &&
                         (empty || (up_addr == next_addr));
    assign flush_any   = flush_pend_q || up_flush;
    assign stall_jump  = !empty && pend && (up_addr != next_addr);
    assign timeout_hit = !empty && (idle_q == IW'(TIMEOUT - 1));
    assign fill_last   = accept && (count_q == CW'(BURST_LEN - 1));
    assign close_run   = (!empty && (full || stall_jump || timeout_hit || flush_any)) || fill_last;
    assign beat_last   = ({1'b0, ptr_q} == (count_q - CW'(1)));

    // Control FSM: collect -> request -> data beats -> (flush ack) -> collect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_COLLECT;
            count_q      <= '0;
            ptr_q        <= '0;
            idle_q       <= '0;
            run_base_q   <= '0;
            flush_pend_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q       <= accept;
            if (accept && (up_addr[1:0] != 2'b00)) err_q <= 1'b1;
            flush_pend_q <= (flush_pend_q && (state_q != S_FLUSH_ACK)) || up_flush;
            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        count_q <= count_q + 1'b1;
                        if (empty) run_base_q <= up_addr;
                    end
                    if (close_run) begin
                        state_q <= S_REQ;
                        idle_q  <= '0;
                    end else if (empty && flush_any) begin
                        state_q <= S_FLUSH_ACK;
                        idle_q  <= '0;
                    end else if (accept || empty) begin
                        idle_q  <= '0;
                    end else begin
                        idle_q  <= idle_q + 1'b1;
                    end
                end
                S_REQ: begin
                    if (dram_burst_ack) begin
                        state_q <= S_DATA;
                        ptr_q   <= '0;
                    end
                end
                S_DATA: begin
                    if (dram_wready) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (beat_last) begin
                            count_q <= '0;
                            state_q <= flush_any ? S_FLUSH_ACK : S_COLLECT;
                        end
                    end
                end
                S_FLUSH_ACK: state_q <= S_COLLECT;
                default:     state_q <= S_COLLECT;
            endcase
        end
    end

    // Run buffer; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clock) begin
        if (accept) buf_q[count_q[PW-1:0]] <= up_data;
    end

    // Outputs are decoded straight from flops and forced to zero when idle.
    assign up_write_done   = done_q;
    assign err_misaligned  = err_q;
    assign flush_done      = (state_q == S_FLUSH_ACK);
    assign dram_burst_req  = (state_q == S_REQ);
    assign dram_burst_addr = dram_burst_req ? run_base_q : '0;
    assign dram_burst_len  = dram_burst_req ? count_q : '0;
    assign dram_wvalid     = (state_q == S_DATA);
    assign dram_wdata      = dram_wvalid ? buf_q[ptr_q] : '0;
    assign dram_wlast      = dram_wvalid && beat_last;

endmodule

// File: tb/tb_delta_dram_write_coalescer.sv
// Bench for delta_dram_write_coalescer: directed scenarios plus a randomized
// write stream, checked against a word-list model that splits runs into bursts.
module tb_delta_dram_write_coalescer;
    localparam int BL = 8;
    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        up_write = 1'b0;
    logic [31:0] up_addr = '0;
    logic [31:0] up_data = '0;
    logic        up_write_done;
    logic        up_flush = 1'b0;
    logic        flush_done;
    logic        dram_burst_req;
    logic [31:0] dram_burst_addr;
    logic [3:0]  dram_burst_len;
    logic        dram_burst_ack = 1'b0;
    logic        dram_wvalid;
    logic [31:0] dram_wdata;
    logic        dram_wlast;
    logic        dram_wready = 1'b0;
    logic        err_misaligned;

    delta_dram_write_coalescer #(.BURST_LEN(BL), .TIMEOUT(TO), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .up_write(up_write), .up_addr(up_addr), .up_data(up_data), .up_write_done(up_write_done),
        .up_flush(up_flush), .flush_done(flush_done),
        .dram_burst_req(dram_burst_req), .dram_burst_addr(dram_burst_addr),
        .dram_burst_len(dram_burst_len), .dram_burst_ack(dram_burst_ack),
        .dram_wvalid(dram_wvalid), .dram_wdata(dram_wdata), .dram_wlast(dram_wlast),
        .dram_wready(dram_wready), .err_misaligned(err_misaligned)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed { logic mk; logic [31:0] a; logic [31:0] d; } ev_t;
    ev_t         model_q[$];
    logic [31:0] obs_a[$];
    logic [3:0]  obs_l[$];
    logic [31:0] obs_d[$];
    logic        obs_last[$];

    // responder / monitor controls
    logic mon_en = 1'b1;
    int   ack_delay = 0;
    logic ack_rand = 1'b0;
    int   wr_mode = 0;
    int   ack_cnt = 0, cur_delay = 0;
    logic tog = 1'b0;
    logic prev_req = 0, prev_ack = 0, prev_wv = 0, prev_wr = 0, prev_last = 0;
    logic [31:0] prev_addr = 0, prev_wdata = 0;
    logic [3:0]  prev_len = 0;
    int   wlast_cyc = -1, req_rise = -1, fd_cnt = 0;
    int   done_cyc = -1, fcyc = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // DRAM-side responder and monitor: chooses ack/wready for the coming edge
    // and records the handshakes that edge will complete.
    always @(negedge clock) begin
        if (!reset) begin
            dram_burst_ack = 1'b0;
            dram_wready    = 1'b0;
            ack_cnt = 0; prev_req = 0; prev_ack = 0; prev_wv = 0; prev_wr = 0;
        end else begin
            if (mon_en && prev_req && !prev_ack) begin
                chk("req_held", dram_burst_req, 1'b1);
                chk("req_addr_stable", dram_burst_addr, prev_addr);
                chk("req_len_stable", dram_burst_len, prev_len);
            end
            if (mon_en && prev_wv && !prev_wr) begin
                chk("beat_held", dram_wvalid, 1'b1);
                chk("beat_data_stable", dram_wdata, prev_wdata);
                chk("beat_last_stable", dram_wlast, prev_last);
            end
            if (dram_burst_req && !prev_req) begin
                req_rise  = cyc;
                cur_delay = ack_rand ? $urandom_range(0, 3) : ack_delay;
            end
            if (dram_burst_req) begin
                if (ack_cnt >= cur_delay) begin dram_burst_ack = 1'b1; ack_cnt = 0; end
                else begin dram_burst_ack = 1'b0; ack_cnt++; end
            end else begin
                dram_burst_ack = 1'b0; ack_cnt = 0;
            end
            case (wr_mode)
                0: dram_wready = 1'b1;
                1: begin tog = !tog; dram_wready = tog; end
                2: dram_wready = 1'($urandom_range(0, 1));
                default: dram_wready = 1'b0;
            endcase
            if (mon_en && dram_burst_req && dram_burst_ack) begin
                obs_a.push_back(dram_burst_addr);
                obs_l.push_back(dram_burst_len);
            end
            if (mon_en && dram_wvalid && dram_wready) begin
                obs_d.push_back(dram_wdata);
                obs_last.push_back(dram_wlast);
                if (dram_wlast) wlast_cyc = cyc + 1;
            end
            if (flush_done) fd_cnt++;
            prev_req = dram_burst_req; prev_ack = dram_burst_ack;
            prev_addr = dram_burst_addr; prev_len = dram_burst_len;
            prev_wv = dram_wvalid; prev_wr = dram_wready;
            prev_wdata = dram_wdata; prev_last = dram_wlast;
        end
    end

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input int gap);
        logic got;
        got = 1'b0;
        @(negedge clock);
        up_write = 1'b1; up_addr = a; up_data = d;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clock);
            if (up_write_done) got = 1'b1;
        end
        chk("write_done", got, 1'b1);
        if (got) begin
            model_q.push_back('{mk: 1'b0, a: a, d: d});
            done_cyc = cyc;
        end
        up_write = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic do_flush();
        logic got;
        got = 1'b0;
        model_q.push_back('{mk: 1'b1, a: 32'h0, d: 32'h0});
        @(negedge clock); up_flush = 1'b1;
        @(negedge clock); up_flush = 1'b0;
        if (flush_done) begin got = 1'b1; fcyc = cyc; end
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clock);
            if (flush_done) begin got = 1'b1; fcyc = cyc; end
        end
        chk("flush_done_seen", got, 1'b1);
    endtask

    // Split the accepted word list into bursts: a new burst starts when the
    // current one is full, the address breaks contiguity, or a close marker.
    task automatic check_bursts(input string tag);
        logic [31:0] ea[$], ed[$], base;
        logic [3:0]  el[$];
        logic        elast[$];
        int n;
        #1;
        n = 0; base = '0;
        foreach (model_q[k]) begin
            if (model_q[k].mk || (n > 0 && (n == BL || model_q[k].a != base + 32'(4 * n)))) begin
                if (n > 0) begin
                    ea.push_back(base); el.push_back(4'(n)); elast[elast.size()-1] = 1'b1;
                end
                n = 0;
            end
            if (!model_q[k].mk) begin
                if (n == 0) base = model_q[k].a;
                ed.push_back(model_q[k].d); elast.push_back(1'b0);
                n++;
            end
        end
        if (n > 0) begin
            ea.push_back(base); el.push_back(4'(n)); elast[elast.size()-1] = 1'b1;
        end
        chk({tag, "_nbursts"}, obs_a.size(), ea.size());
        for (int i = 0; i < ea.size() && i < obs_a.size(); i++) begin
            chk({tag, "_addr"}, obs_a[i], ea[i]);
            chk({tag, "_len"}, obs_l[i], el[i]);
        end
        chk({tag, "_nbeats"}, obs_d.size(), ed.size());
        for (int i = 0; i < ed.size() && i < obs_d.size(); i++) begin
            chk({tag, "_data"}, obs_d[i], ed[i]);
            chk({tag, "_wlast"}, obs_last[i], elast[i]);
        end
        model_q.delete(); obs_a.delete(); obs_l.delete(); obs_d.delete(); obs_last.delete();
    endtask

    initial begin
        int fd0, last8;
        logic [31:0] a;

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_req", dram_burst_req, 1'b0);
        chk("rst_wvalid", dram_wvalid, 1'b0);
        chk("rst_done", up_write_done, 1'b0);
        chk("rst_fdone", flush_done, 1'b0);
        chk("rst_err", err_misaligned, 1'b0);
        @(negedge clock); reset = 1'b1;

        // full burst of 8 from 0x1000
        for (int i = 0; i < 8; i++) write_word(32'h1000 + 32'(4 * i), 32'hA000 + 32'(i), 0);
        last8 = done_cyc;
        do_flush();
        chk("full_req_latency", req_rise, last8);
        check_bursts("full8");

        // 3 words then flush; flush_done one cycle after the last beat
        for (int i = 0; i < 3; i++) write_word(32'h2000 + 32'(4 * i), 32'hB000 + 32'(i), 0);
        do_flush();
        chk("flush_after_wlast", fcyc, wlast_cyc);
        check_bursts("flush3");

        // non-contiguous word stalls until the previous run drains
        write_word(32'h1000, 32'hC0, 0);
        write_word(32'h1004, 32'hC1, 0);
        write_word(32'h3000, 32'hC2, 0);
        chk("jump_done_after_wlast", done_cyc, wlast_cyc + 1);
        do_flush();
        check_bursts("jump");

        // idle timeout closes the run without a flush
        #1 fd0 = fd_cnt;
        write_word(32'h5000, 32'hD0, 0);
        write_word(32'h5004, 32'hD1, 0);
        repeat (40) @(negedge clock);
        #1;
        chk("timeout_req_time", req_rise, done_cyc + TO);
        chk("timeout_no_fdone", fd_cnt, fd0);
        model_q.push_back('{mk: 1'b1, a: 32'h0, d: 32'h0});
        check_bursts("timeout");

        // slow ack and toggling wready
        ack_delay = 5; wr_mode = 1;
        for (int i = 0; i < 8; i++) write_word(32'h7000 + 32'(4 * i), $urandom, 0);
        do_flush();
        check_bursts("slow");

        // randomized stream
        ack_rand = 1'b1; wr_mode = 2;
        a = 32'h0001_0000;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [31:0] j;
                j = {16'h0002, 14'($urandom), 2'b00};
                if (j == a + 32'd4) j = j + 32'h100;
                a = j;
            end else begin
                a = a + 32'd4;
            end
            write_word(a, $urandom, $urandom_range(0, 3));
        end
        do_flush();
        check_bursts("random");

        // reset mid data phase
        ack_rand = 1'b0; ack_delay = 0; wr_mode = 3;
        for (int i = 0; i < 4; i++) write_word(32'h6000 + 32'(4 * i), 32'hE0 + 32'(i), 0);
        @(negedge clock); up_flush = 1'b1;
        @(negedge clock); up_flush = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clock);
                if (dram_wvalid) seen = 1'b1;
            end
            chk("reached_data", seen, 1'b1);
        end
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_wvalid", dram_wvalid, 1'b0);
        chk("mid_rst_wdata", dram_wdata, 32'h0);
        chk("mid_rst_wlast", dram_wlast, 1'b0);
        chk("mid_rst_req", dram_burst_req, 1'b0);
        chk("mid_rst_fdone", flush_done, 1'b0);
        model_q.delete(); obs_a.delete(); obs_l.delete(); obs_d.delete(); obs_last.delete();
        @(negedge clock); @(negedge clock);
        reset = 1'b1; wr_mode = 0; mon_en = 1'b1;
        @(negedge clock); up_flush = 1'b1;
        @(negedge clock); up_flush = 1'b0;
        chk("empty_flush_done", flush_done, 1'b1);
        chk("empty_flush_noreq", dram_burst_req, 1'b0);
        @(negedge clock);
        chk("empty_flush_pulse", flush_done, 1'b0);

        // misaligned address is sticky until reset
        write_word(32'h1002, 32'hF0, 0);
        chk("err_set", err_misaligned, 1'b1);
        do_flush();
        check_bursts("misalign");
        chk("err_sticky", err_misaligned, 1'b1);
        @(negedge clock); reset = 1'b0;
        #1 chk("err_cleared", err_misaligned, 1'b0);
        @(negedge clock); reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
